// File: rtl/stopwatch_axil_pkg.sv
// rtl/stopwatch_axil_pkg.sv - slot map, response codes and command bits for the stopwatch register block
package stopwatch_axil_pkg;
  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_CTRL     = 3'd0;
  localparam slot_t SLOT_DIV      = 3'd1;
  localparam slot_t SLOT_SCRATCH0 = 3'd2;
  localparam slot_t SLOT_SCRATCH1 = 3'd3;
  localparam slot_t SLOT_ELAPSED  = 3'd4;
  localparam slot_t SLOT_LAP      = 3'd5;
  localparam slot_t SLOT_CMD      = 3'd6;
  localparam slot_t SLOT_UNMAP    = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CMD_CLR_BIT = 0;
  localparam int CMD_LAP_BIT = 1;
endpackage

// File: rtl/stopwatch_tick_gen.sv
// rtl/stopwatch_tick_gen.sv - prescaler, elapsed counter and lap capture
module stopwatch_tick_gen #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [31:0]          div,
  input  logic                 clr,
  input  logic                 lap,
  output logic [CNT_WIDTH-1:0] elapsed,
  output logic [CNT_WIDTH-1:0] lap_count,
  output logic                 tick
);
  logic [31:0] presc;

  // A clear in the same cycle swallows the tick, so no pulse without an increment.
  assign tick = run && !clr && (presc == div);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      elapsed   <= '0;
      lap_count <= '0;
    end else begin
      if (lap) begin
        lap_count <= elapsed;
      end
      if (clr) begin
        presc   <= '0;
        elapsed <= '0;
      end else if (tick) begin
        presc   <= '0;
        elapsed <= elapsed + CNT_WIDTH'(1);
      end else if (run) begin
        presc <= presc + 32'd1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_axil_regs.sv
// rtl/stopwatch_axil_regs.sv - AXI4-Lite register block for the stopwatch peripheral
// STOPWATCH_AXIL_SLVERR_EN: report SLVERR for unmapped, CMD-read and RO-write accesses
module stopwatch_axil_regs
  import stopwatch_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            sw_running,
  output logic                            sw_tick
);
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic [CNT_WIDTH-1:0]          elapsed;
  logic [CNT_WIDTH-1:0]          lap_count;
  slot_t                         wr_slot;
  slot_t                         rd_slot;
  logic aw_accept, ar_accept, wr_fire, rd_fire;
  logic wr_err, rd_err, cmd_wr, cmd_clr, cmd_lap;
  logic unused_inputs;

  assign wr_slot = s00_axi_awaddr[4:2];
  assign rd_slot = s00_axi_araddr[4:2];
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_accept = s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
  assign ar_accept = s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
  assign wr_fire   = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
  assign rd_fire   = s00_axi_arready && s00_axi_arvalid;

`ifdef STOPWATCH_AXIL_SLVERR_EN
  assign wr_err = (wr_slot == SLOT_ELAPSED) || (wr_slot == SLOT_LAP) || (wr_slot == SLOT_UNMAP);
  assign rd_err = (rd_slot == SLOT_CMD) || (rd_slot == SLOT_UNMAP);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign cmd_wr  = wr_fire && !wr_err && (wr_slot == SLOT_CMD) && s00_axi_wstrb[0];
  assign cmd_clr = cmd_wr && s00_axi_wdata[CMD_CLR_BIT];
  assign cmd_lap = cmd_wr && s00_axi_wdata[CMD_LAP_BIT];

  assign sw_running = regs[SLOT_CTRL][0];

  stopwatch_tick_gen #(.CNT_WIDTH(CNT_WIDTH)) u_tick_gen (
    .clk       (s00_axi_aclk),
    .reset     (s00_axi_areset),
    .run       (regs[SLOT_CTRL][0]),
    .div       (regs[SLOT_DIV]),
    .clr       (cmd_clr),
    .lap       (cmd_lap),
    .elapsed   (elapsed),
    .lap_count (lap_count),
    .tick      (sw_tick)
  );

  always_comb begin
    rd_data = '0;
    case (rd_slot)
      SLOT_CTRL, SLOT_DIV, SLOT_SCRATCH0, SLOT_SCRATCH1: rd_data = regs[rd_slot[1:0]];
      SLOT_ELAPSED:          rd_data = C_S_AXI_DATA_WIDTH'(elapsed);
      SLOT_LAP:              rd_data = C_S_AXI_DATA_WIDTH'(lap_count);
      SLOT_CMD, SLOT_UNMAP:  rd_data = '0;
    endcase
  end

  // Only slots 0-3 are backing storage; everything else is decoded or read-only.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_fire && !wr_err && !wr_slot[2]) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s00_axi_wstrb[b]) regs[wr_slot[1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rresp   <= RESP_OKAY;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_awready <= aw_accept;
      s00_axi_wready  <= aw_accept;
      s00_axi_arready <= ar_accept;
      if (wr_fire) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
      if (rd_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_data;
        s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_axil_regs.sv
// tb/tb_stopwatch_axil_regs.sv - self-checking bench for stopwatch_axil_regs
// Honours STOPWATCH_AXIL_SLVERR_EN when deciding expected error responses.
module tb_stopwatch_axil_regs;
  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        sw_running, sw_tick;

  int total = 0, bad = 0, cyc = 0, tick_cnt = 0, last_fire = 0;
  logic [31:0] model [4];
  logic [31:0] exp_elapsed, exp_lap;

  stopwatch_axil_regs dut (
    .s00_axi_aclk(tb_ACLK), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .sw_running(sw_running), .sw_tick(sw_tick)
  );

  always #5 tb_ACLK = ~tb_ACLK;
  always @(posedge tb_ACLK) cyc = cyc + 1;
  always @(negedge tb_ACLK) if (sw_tick === 1'b1) tick_cnt = tick_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // last_fire records the posedge index at which the write handshake completes.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge tb_ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge tb_ACLK); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL write_aw_timeout addr=%h", a); end
    last_fire = cyc + 1;
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge tb_ACLK); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL write_b_timeout addr=%h", a); end
    resp = bresp; bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge tb_ACLK);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge tb_ACLK); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL read_ar_timeout addr=%h", a); end
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(negedge tb_ACLK); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL read_r_timeout addr=%h", a); end
    d = rdata; resp = rresp; rready = 1'b1;
    @(negedge tb_ACLK);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    areset = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    total++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin bad++; $display("FAIL reset_handshake got=%b want=00000", {awready, wready, bvalid, arready, rvalid}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if ({bresp, rresp} !== 4'b0) begin bad++; $display("FAIL reset_resp got=%b want=0000", {bresp, rresp}); end
    total++; if ({sw_running, sw_tick} !== 2'b0) begin bad++; $display("FAIL reset_status got=%b want=00", {sw_running, sw_tick}); end
    areset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      axi_read(5'(i * 4), d, r);
      total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL reset_read slot=%0d got=%h/%b want=0/00", i, d, r); end
    end
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    exp_elapsed = 0; exp_lap = 0;
  endtask

  task automatic test_regs;
    logic [31:0] pat [4]; logic [31:0] d, v; logic [3:0] s; logic [1:0] br, rr; int slot;
    pat = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), pat[i], 4'hF, br);
      model[i] = pat[i];
      axi_read(5'(i * 4), d, rr);
      total++; if (d !== model[i]) begin bad++; $display("FAIL regs_read slot=%0d got=%h want=%h", i, d, model[i]); end
      total++; if (br !== 2'b00 || rr !== 2'b00) begin bad++; $display("FAIL regs_resp slot=%0d got=%b/%b want=00/00", i, br, rr); end
    end
    total++; if (sw_running !== 1'b1) begin bad++; $display("FAIL regs_running got=%b want=1", sw_running); end
    repeat (6) begin
      slot = $urandom_range(1, 3); v = $urandom; s = 4'($urandom_range(0, 15));
      axi_write(5'(slot * 4), v, s, br);
      for (int b = 0; b < 4; b++) if (s[b]) model[slot][8*b +: 8] = v[8*b +: 8];
      axi_read(5'(slot * 4), d, rr);
      total++; if (d !== model[slot]) begin bad++; $display("FAIL regs_rand slot=%0d strb=%b got=%h want=%h", slot, s, d, model[slot]); end
    end
    axi_write(5'h00, 32'h0, 4'hF, br);
    model[0] = 32'h0;
    total++; if (sw_running !== 1'b0) begin bad++; $display("FAIL regs_stopped got=%b want=0", sw_running); end
  endtask

  task automatic test_strobe;
    logic [31:0] d; logic [1:0] r;
    axi_write(5'h08, 32'hFFFFFFFF, 4'hF, r);
    axi_write(5'h08, 32'h00000000, 4'b0010, r);
    model[2] = 32'hFFFF00FF;
    axi_read(5'h08, d, r);
    total++; if (d !== 32'hFFFF00FF) begin bad++; $display("FAIL strobe_merge got=%h want=ffff00ff", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2, d; logic [1:0] r; int n_aw, n_w, n_pair, n; bit seen;
    d1 = $urandom; d2 = $urandom;
    n_aw = 0; n_w = 0; n_pair = 0; seen = 0;
    @(negedge tb_ACLK);
    awaddr = 5'h0C; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    repeat (5) begin
      @(negedge tb_ACLK);
      total++; if (awready !== 1'b0) begin bad++; $display("FAIL b2b_aw_without_w got=%b want=0", awready); end
    end
    wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_ACLK);
      if (seen) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (awready === 1'b1) n_aw++;
      if (wready === 1'b1) n_w++;
      if (awready === 1'b1 && wready === 1'b1) n_pair++;
      if (awready === 1'b1) seen = 1;
    end
    total++; if (n_aw != 1 || n_w != 1 || n_pair != 1) begin bad++; $display("FAIL b2b_ready_pulse got=aw%0d/w%0d/pair%0d want=1/1/1", n_aw, n_w, n_pair); end
    awaddr = 5'h08; wdata = d2; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) begin
      @(negedge tb_ACLK);
      total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL b2b_bvalid_hold got=%b want=1", bvalid); end
      total++; if (awready !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", awready); end
    end
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL b2b_second_accept got=timeout want=awready"); end
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    model[3] = d1; model[2] = d2;
    axi_read(5'h0C, d, r);
    total++; if (d !== model[3]) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", d, model[3]); end
    axi_read(5'h08, d, r);
    total++; if (d !== model[2]) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", d, model[2]); end
  endtask

  task automatic test_simul;
    logic [31:0] old, nw, d; logic [1:0] r; int n;
    old = model[2]; nw = $urandom;
    @(negedge tb_ACLK);
    awaddr = 5'h08; araddr = 5'h08; wdata = nw; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL simul_arready got=%b want=1", arready); end
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while ((bvalid !== 1'b1 || rvalid !== 1'b1) && n < 20) begin @(negedge tb_ACLK); n++; end
    total++; if (rdata !== old) begin bad++; $display("FAIL simul_old_data got=%h want=%h", rdata, old); end
    bready = 1'b1; rready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0; rready = 1'b0;
    model[2] = nw;
    axi_read(5'h08, d, r);
    total++; if (d !== nw) begin bad++; $display("FAIL simul_new_data got=%h want=%h", d, nw); end
  endtask

  task automatic test_prescaler;
    logic [31:0] v1, v2; logic [1:0] r; int d, k, c0, c1;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 4 : $urandom_range(0, 5);
      k = (it == 0) ? 50 : $urandom_range(20, 60);
      axi_write(5'h04, 32'(d), 4'hF, r); model[1] = 32'(d);
      axi_write(5'h18, 32'h1, 4'hF, r);
      tick_cnt = 0;
      axi_write(5'h00, 32'h1, 4'hF, r); c0 = last_fire; model[0] = 32'h1;
      repeat (k) @(negedge tb_ACLK);
      total++; if (sw_running !== 1'b1) begin bad++; $display("FAIL presc_running got=%b want=1", sw_running); end
      axi_write(5'h00, 32'h0, 4'hF, r); c1 = last_fire; model[0] = 32'h0;
      exp_elapsed = 32'((c1 - c0) / (d + 1));
      axi_read(5'h10, v1, r);
      repeat (20) @(negedge tb_ACLK);
      axi_read(5'h10, v2, r);
      total++; if (v1 !== exp_elapsed) begin bad++; $display("FAIL presc_elapsed div=%0d got=%0d want=%0d", d, v1, exp_elapsed); end
      total++; if (v2 !== exp_elapsed) begin bad++; $display("FAIL presc_frozen div=%0d got=%0d want=%0d", d, v2, exp_elapsed); end
      total++; if (tick_cnt != int'(exp_elapsed)) begin bad++; $display("FAIL presc_ticks div=%0d got=%0d want=%0d", d, tick_cnt, exp_elapsed); end
    end
  endtask

  task automatic test_lap;
    logic [31:0] v; logic [1:0] r; int d, c0, cc, c1;
    d = int'(model[1]);
    axi_write(5'h18, 32'h2, 4'hF, r); exp_lap = exp_elapsed;
    axi_write(5'h18, 32'h1, 4'hF, r); exp_elapsed = 0;
    axi_read(5'h14, v, r);
    total++; if (v !== exp_lap) begin bad++; $display("FAIL lap_capture got=%0d want=%0d", v, exp_lap); end
    axi_read(5'h10, v, r);
    total++; if (v !== exp_elapsed) begin bad++; $display("FAIL lap_clear got=%0d want=%0d", v, exp_elapsed); end
    axi_write(5'h00, 32'h1, 4'hF, r); c0 = last_fire;
    repeat ($urandom_range(20, 40)) @(negedge tb_ACLK);
    axi_write(5'h18, 32'h3, 4'hF, r); cc = last_fire;
    exp_lap = 32'((cc - 1 - c0) / (d + 1));
    repeat ($urandom_range(20, 40)) @(negedge tb_ACLK);
    axi_write(5'h00, 32'h0, 4'hF, r); c1 = last_fire;
    exp_elapsed = 32'((c1 - cc) / (d + 1));
    axi_write(5'h18, 32'h3, 4'b1110, r);
    axi_read(5'h14, v, r);
    total++; if (v !== exp_lap) begin bad++; $display("FAIL lap_both_capture got=%0d want=%0d", v, exp_lap); end
    axi_read(5'h10, v, r);
    total++; if (v !== exp_elapsed) begin bad++; $display("FAIL lap_both_elapsed got=%0d want=%0d", v, exp_elapsed); end
  endtask

  task automatic test_slverr;
    logic [31:0] v; logic [1:0] r, exp_err;
`ifdef STOPWATCH_AXIL_SLVERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    axi_read(5'h1C, v, r);
    total++; if (r !== exp_err || v !== 32'h0) begin bad++; $display("FAIL err_rd_unmap got=%b/%h want=%b/0", r, v, exp_err); end
    axi_read(5'h18, v, r);
    total++; if (r !== exp_err || v !== 32'h0) begin bad++; $display("FAIL err_rd_cmd got=%b/%h want=%b/0", r, v, exp_err); end
    axi_write(5'h10, $urandom, 4'hF, r);
    total++; if (r !== exp_err) begin bad++; $display("FAIL err_wr_elapsed got=%b want=%b", r, exp_err); end
    axi_read(5'h10, v, r);
    total++; if (v !== exp_elapsed) begin bad++; $display("FAIL err_elapsed_kept got=%0d want=%0d", v, exp_elapsed); end
    axi_write(5'h1C, $urandom, 4'hF, r);
    total++; if (r !== exp_err) begin bad++; $display("FAIL err_wr_unmap got=%b want=%b", r, exp_err); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v; logic [1:0] r; int n;
    @(negedge tb_ACLK);
    awaddr = 5'h0C; wdata = $urandom | 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL midrst_pending got=%b want=1", bvalid); end
    areset = 1'b1;
    @(negedge tb_ACLK);
    areset = 1'b0;
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL midrst_bvalid got=%b want=0", bvalid); end
    axi_read(5'h0C, v, r);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midrst_reg got=%h want=0", v); end
  endtask

  initial begin
    areset = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    test_reset();
    test_regs();
    test_strobe();
    test_back_to_back();
    test_simul();
    test_prescaler();
    test_lap();
    test_slverr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_axil_regs.md
Name: stopwatch_axil_regs

Overview:
- AXI4-Lite slave register block for the stopwatch peripheral; sits directly downstream of the AXI4-Lite master (PS interconnect, or the lite master BFM in simulation).
- Provides four read/write control/scratch registers at 0x00–0x0C, which the existing write/readback bench exercises unchanged.
- Adds a prescaled elapsed-time counter, a lap-capture register and a command strobe register.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.
CNT_WIDTH, 32, elapsed/lap counter width (≤32; zero-extended on read).

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_areset  in  1  synchronous reset, active-high
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
sw_running  out  1  copy of CTRL[0]
sw_tick  out  1  one-cycle pulse per counter increment

Behaviour:
- Reset (sync, active-high): all ready/valid outputs 0; bresp/rresp 2'b00; rdata 0; REG0–REG3, prescaler, ELAPSED and LAP all 0.
- Address map (word index = addr[4:2]; addr[1:0] ignored):
  - 0 CTRL RW; bit0 = run.
  - 1 DIV RW; tick period = DIV+1 clocks.
  - 2, 3 SCRATCH RW.
  - 4 ELAPSED RO.
  - 5 LAP RO.
  - 6 CMD WO; reads 0.
  - 7 unmapped.
- Write handshake:
  - Accept only when awvalid & wvalid & !bvalid & !awready.
  - awready and wready pulse high together for exactly one cycle.
  - Register update occurs in that same accept cycle, per byte where wstrb[i]=1.
  - bvalid rises the next cycle and holds until bready; the next accept is blocked while bvalid=1.
  - AW without W (or W without AW) waits; no skid buffering.
- Read handshake:
  - Accept when arvalid & !rvalid & !arready; arready pulses one cycle.
  - rvalid and rdata are registered the next cycle; rdata is held stable until rvalid & rready.
  - Read data is sampled at accept + 1 edge.
- Simultaneous read and write in one cycle: both channels are accepted independently. A read of the same address returns the pre-write value.
- Writes to RO slots: no effect, response OKAY.
- CMD (write-only strobe, honoured only if wstrb[0]=1):
  - bit0 clear: ELAPSED ← 0 and prescaler ← 0.
  - bit1 lap: LAP ← current ELAPSED.
  - Both bits set together: LAP captures the pre-clear ELAPSED, then ELAPSED clears.
- Prescaler:
  - Increments each cycle while CTRL[0]=1.
  - When prescaler == DIV: prescaler ← 0, ELAPSED ← ELAPSED+1, sw_tick=1 that cycle.
  - ELAPSED wraps from all-ones to 0 silently.
  - Stop (run=0) freezes prescaler and ELAPSED.
  - DIV written below the current prescaler value: the prescaler runs on to wrap at 2^32, with no forced reload.
- A clear command in the same cycle as a tick wins; ELAPSED = 0.
- Reset asserted mid-transaction: all channels abandon the transaction; the master must reissue.

Optional Feature:
- Macro: STOPWATCH_AXIL_SLVERR_EN.
- Defined:
  - Accesses to slot 7, reads of CMD and writes to ELAPSED/LAP return SLVERR (2'b10).
  - A write that gets SLVERR has no side effects.
- Undefined: all of these return OKAY; unmapped and CMD reads give rdata 0.

Decomposition:
- Package stopwatch_axil_pkg holds:
  - slot index constants (SLOT_CTRL..SLOT_UNMAP);
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - CMD bit positions.
- One sub-module: stopwatch_tick_gen (prescaler + ELAPSED + LAP). Interface: run, div, clr, lap inputs; elapsed, lap, tick outputs.
- AXI channel logic stays in the top.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x00/04/08/0C, each followed by a read → each read matches, bresp = rresp = 0.
- Write 0xFFFFFFFF to 0x08, then write 0x00000000 with wstrb=4'b0010 → read 0x08 returns 0xFFFF00FF.
- DIV=4, CTRL=1 for 50 clocks, then CTRL=0 → ELAPSED = 10 ± 1; value stable on two reads 20 clocks apart.
- Write CMD=0x2, then CMD=0x1 → LAP keeps the prior ELAPSED value, ELAPSED reads 0; a CMD 0x3 write captures and clears.
- AW presented 5 cycles before W, bready held low 3 cycles → awready and wready pulse together in one cycle; bvalid holds; a second write stalls until B completes.
- With STOPWATCH_AXIL_SLVERR_EN: read 0x1C → rresp = 2'b10; write 0x10 → bresp = 2'b10 and ELAPSED unchanged. Without the macro: both return OKAY.
